// File: rtl/cart_loader_pkg.sv
// Shared types and constants for the iNES cartridge loader.
package cart_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_TRAINER,
    ST_PRG,
    ST_CHR,
    ST_DONE,
    ST_ERROR
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_MAGIC   = 2'd1;
  localparam logic [1:0] ERR_SIZE    = 2'd2;
  localparam logic [1:0] ERR_TRAINER = 2'd3;

  // Element 0 is the first byte on the wire: "NES" followed by 0x1A.
  localparam logic [3:0][7:0] INES_MAGIC = {8'h1A, 8'h53, 8'h45, 8'h4E};

  localparam int HDR_LEN        = 16;
  localparam int TRAINER_LEN    = 512;
  localparam int PRG_BANK_BYTES = 16384;
  localparam int CHR_BANK_BYTES = 8192;

endpackage

// File: rtl/cart_hdr_decode.sv
// Captures iNES header fields as bytes arrive and flags magic/size problems.
module cart_hdr_decode
  import cart_loader_pkg::*;
#(
  parameter int PRG_AW = 17,
  parameter int CHR_AW = 13
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       hdr_we,
  input  logic [3:0] hdr_idx,
  input  logic [7:0] hdr_data,
  output logic [7:0] mapper,
  output logic [7:0] prg_banks,
  output logic [7:0] chr_banks,
  output logic       mirror_v,
  output logic       battery,
  output logic       trainer,
  output logic       magic_err,
  output logic       size_err
);

  localparam logic [8:0] PRG_MAX = 9'(1 << (PRG_AW - 14));
  localparam logic [8:0] CHR_MAX = 9'(1 << (CHR_AW - 13));

  logic [7:0] mapper_q, mapper_d;
  logic [7:0] prg_q, prg_d;
  logic [7:0] chr_q, chr_d;
  logic       mirror_q, mirror_d;
  logic       battery_q, battery_d;
  logic       trainer_q, trainer_d;

  always_comb begin
    mapper_d  = mapper_q;
    prg_d     = prg_q;
    chr_d     = chr_q;
    mirror_d  = mirror_q;
    battery_d = battery_q;
    trainer_d = trainer_q;
    if (clr) begin
      mapper_d  = '0;
      prg_d     = '0;
      chr_d     = '0;
      mirror_d  = 1'b0;
      battery_d = 1'b0;
      trainer_d = 1'b0;
    end else if (hdr_we) begin
      case (hdr_idx)
        4'd4: prg_d = hdr_data;
        4'd5: chr_d = hdr_data;
        4'd6: begin
          mirror_d       = hdr_data[0];
          battery_d      = hdr_data[1];
          trainer_d      = hdr_data[2];
          mapper_d[3:0]  = hdr_data[7:4];
        end
        4'd7: mapper_d[7:4] = hdr_data[7:4];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      mapper_q  <= '0;
      prg_q     <= '0;
      chr_q     <= '0;
      mirror_q  <= 1'b0;
      battery_q <= 1'b0;
      trainer_q <= 1'b0;
    end else begin
      mapper_q  <= mapper_d;
      prg_q     <= prg_d;
      chr_q     <= chr_d;
      mirror_q  <= mirror_d;
      battery_q <= battery_d;
      trainer_q <= trainer_d;
    end
  end

  assign magic_err = hdr_we && (hdr_idx[3:2] == 2'b00) &&
                     (hdr_data != INES_MAGIC[hdr_idx[1:0]]);
  // Bytes 4/5 are already registered by the time byte 15 is checked.
  assign size_err  = (prg_q == 8'd0) || ({1'b0, prg_q} > PRG_MAX) ||
                     ({1'b0, chr_q} > CHR_MAX);

  assign mapper    = mapper_q;
  assign prg_banks = prg_q;
  assign chr_banks = chr_q;
  assign mirror_v  = mirror_q;
  assign battery   = battery_q;
  assign trainer   = trainer_q;

endmodule

// File: rtl/cart_loader.sv
// Streams an iNES image into PRG/CHR memory and holds the cart in reset until loaded.
// Define CART_LOADER_TRAINER_SKIP_EN to skip a 512-byte trainer instead of rejecting it.
module cart_loader
  import cart_loader_pkg::*;
#(
  parameter int PRG_AW = 17,
  parameter int CHR_AW = 13
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic              mem_sel,
  output logic [PRG_AW-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic [7:0]        mapper,
  output logic [7:0]        prg_banks,
  output logic [7:0]        chr_banks,
  output logic              mirror_v,
  output logic              battery,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic              cart_rst
);

  localparam int CW = PRG_AW + 1;
  localparam logic [CW-1:0] HDR_LAST = CW'(HDR_LEN - 1);
  localparam logic [CW-1:0] TRN_LAST = CW'(TRAINER_LEN - 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              mem_we_q, mem_we_d;
  logic              mem_sel_q, mem_sel_d;
  logic [PRG_AW-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_data_q, mem_data_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              cart_rst_q, cart_rst_d;

  logic          loading, accept, hdr_we, hdr_clr;
  logic          trainer, magic_err, size_err;
  logic [CW-1:0] cnt_inc, prg_end, chr_end;

  assign loading = (state_q == ST_HEADER) || (state_q == ST_TRAINER) ||
                   (state_q == ST_PRG) || (state_q == ST_CHR);
  assign accept  = in_valid && loading;
  assign hdr_we  = accept && (state_q == ST_HEADER);
  assign hdr_clr = start && !loading;
  assign cnt_inc = cnt_q + CW'(1);
  // Bank counts are bounded by the size check, so the products fit in CW bits.
  assign prg_end = CW'(prg_banks) * CW'(PRG_BANK_BYTES);
  assign chr_end = CW'(chr_banks) * CW'(CHR_BANK_BYTES);

  cart_hdr_decode #(.PRG_AW(PRG_AW), .CHR_AW(CHR_AW)) u_hdr (
    .clk_sys   (clk_sys),
    .rst_n     (rst_n),
    .clr       (hdr_clr),
    .hdr_we    (hdr_we),
    .hdr_idx   (cnt_q[3:0]),
    .hdr_data  (in_data),
    .mapper    (mapper),
    .prg_banks (prg_banks),
    .chr_banks (chr_banks),
    .mirror_v  (mirror_v),
    .battery   (battery),
    .trainer   (trainer),
    .magic_err (magic_err),
    .size_err  (size_err)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mem_we_d   = 1'b0;
    mem_sel_d  = mem_sel_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    err_code_d = err_code_q;
    cart_rst_d = 1'b1;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d    = ST_HEADER;
          cnt_d      = '0;
          err_code_d = ERR_NONE;
        end else if (state_q == ST_DONE) begin
          // Released one cycle after DONE so the final write lands first.
          cart_rst_d = 1'b0;
        end
      end
      ST_HEADER: begin
        if (accept) begin
          cnt_d = cnt_inc;
          if (magic_err) begin
            state_d    = ST_ERROR;
            err_code_d = ERR_MAGIC;
          end else if (cnt_q == HDR_LAST) begin
            cnt_d = '0;
            if (size_err) begin
              state_d    = ST_ERROR;
              err_code_d = ERR_SIZE;
            end else if (trainer) begin
`ifdef CART_LOADER_TRAINER_SKIP_EN
              state_d = ST_TRAINER;
`else
              state_d    = ST_ERROR;
              err_code_d = ERR_TRAINER;
`endif
            end else begin
              state_d = ST_PRG;
            end
          end
        end
      end
      ST_TRAINER: begin
        if (accept) begin
          cnt_d = cnt_inc;
          if (cnt_q == TRN_LAST) begin
            cnt_d   = '0;
            state_d = ST_PRG;
          end
        end
      end
      ST_PRG, ST_CHR: begin
        if (accept) begin
          mem_we_d   = 1'b1;
          mem_sel_d  = (state_q == ST_CHR);
          mem_addr_d = cnt_q[PRG_AW-1:0];
          mem_data_d = in_data;
          cnt_d      = cnt_inc;
          if ((state_q == ST_PRG) && (cnt_inc == prg_end)) begin
            cnt_d   = '0;
            state_d = (chr_banks != 8'd0) ? ST_CHR : ST_DONE;
          end else if ((state_q == ST_CHR) && (cnt_inc == chr_end)) begin
            cnt_d   = '0;
            state_d = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      mem_we_q   <= 1'b0;
      mem_sel_q  <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      err_code_q <= ERR_NONE;
      cart_rst_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mem_we_q   <= mem_we_d;
      mem_sel_q  <= mem_sel_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      err_code_q <= err_code_d;
      cart_rst_q <= cart_rst_d;
    end
  end

  assign in_ready = loading;
  assign busy     = loading;
  assign done     = (state_q == ST_DONE);
  assign error    = (state_q == ST_ERROR);
  assign mem_we   = mem_we_q;
  assign mem_sel  = mem_sel_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign err_code = err_code_q;
  assign cart_rst = cart_rst_q;

endmodule
